// File: rtl/ascii_frame_packer.sv
// ascii_frame_packer: packs a valid/ready byte stream into one wide frame.
// The first byte lands in the top byte; unfilled bytes read as zero.
// A frame closes on a NUL byte, on the NBYTES-th byte, or after TIMEOUT_CYC
// idle cycles inside a partial frame. It is then held until frame_ack.
// Optional feature macro: ASCII_CHECKSUM_EN adds the frame_sum output.
module ascii_frame_packer #(
  parameter int unsigned NBYTES      = 24,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned W          = 8 * NBYTES,
  localparam int unsigned LW         = $clog2(NBYTES + 1),
  localparam int unsigned TW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  frame_data,
  output logic [LW-1:0] frame_len,
  output logic          frame_valid,
  input  logic          frame_ack
`ifdef ASCII_CHECKSUM_EN
  ,
  output logic [7:0]    frame_sum
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [TW-1:0] idle_inc;
  logic          ready_q, ready_d;
  logic          accept;
`ifdef ASCII_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // Ready is registered so it stays low during reset and rises one edge later.
  assign accept = in_valid && ready_q;

  // Next-state: byte storage, frame close conditions and the ack handshake.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    idle_inc = (idle_q == TW'(TIMEOUT_CYC)) ? idle_q : idle_q + TW'(1);
`ifdef ASCII_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          data_d[W - 1 - 8 * int'(cnt_q) -: 8] = in_data;
          cnt_d  = cnt_q + LW'(1);
          idle_d = '0;
`ifdef ASCII_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if ((in_data == 8'h00) || (cnt_q == LW'(NBYTES - 1))) begin
            state_d = StDone;
          end else begin
            state_d = StFill;
          end
        end else if ((state_q == StFill) && (TIMEOUT_CYC != 0)) begin
          // Close on the edge where the idle count reaches the limit.
          idle_d = idle_inc;
          if (idle_inc == TW'(TIMEOUT_CYC)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (frame_ack) begin
          state_d = StIdle;
          data_d  = '0;
          cnt_d   = '0;
          idle_d  = '0;
`ifdef ASCII_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    ready_d = (state_d != StDone);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      ready_q <= 1'b0;
`ifdef ASCII_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      ready_q <= ready_d;
`ifdef ASCII_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Outputs come straight from flops; the buffer is frozen while in StDone.
  always_comb begin
    in_ready    = ready_q;
    frame_data  = data_q;
    frame_len   = cnt_q;
    frame_valid = (state_q == StDone);
`ifdef ASCII_CHECKSUM_EN
    frame_sum   = sum_q;
`endif
  end

endmodule

// File: tb/tb_ascii_frame_packer.sv
// Scoreboard bench for ascii_frame_packer: the stimulus process pushes the
// expected frame of each planned byte string; a monitor pops and compares
// whenever frame_valid is seen, then acknowledges after a random delay.
module tb_ascii_frame_packer;

  localparam int unsigned NB = 24;
  localparam int unsigned TO = 64;
  localparam int unsigned W  = 8 * NB;
  localparam int unsigned LW = $clog2(NB + 1);

  typedef struct {
    logic [W-1:0]  data;
    logic [LW-1:0] len;
    logic [7:0]    sum;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  frame_data;
  logic [LW-1:0] frame_len;
  logic          frame_valid;
  logic          frame_ack;
  logic          mon_ack;
  logic          stim_ack;
  logic          hold_ack;
`ifdef ASCII_CHECKSUM_EN
  logic [7:0]    frame_sum;
`endif

  int            checks;
  int            errors;
  exp_t          sb[$];
  logic [7:0]    plan[$];

  assign frame_ack = mon_ack | stim_ack;

  ascii_frame_packer #(
    .NBYTES      (NB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack)
`ifdef ASCII_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: characters packed from the top byte down, zero fill below,
  // length is the number of characters, sum is their total mod 256.
  task automatic push_plan();
    exp_t e;
    e.data = '0;
    e.sum  = 8'h00;
    foreach (plan[i]) begin
      e.data = (e.data << 8) | W'(plan[i]);
      e.sum  = e.sum + plan[i];
    end
    e.data = e.data << (8 * (NB - plan.size()));
    e.len  = LW'(plan.size());
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_wait_bound", 1, 0);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_plan(input int gap_max, input bit timeout);
    push_plan();
    foreach (plan[i]) begin
      if (i > 0 && gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      send_byte(plan[i]);
    end
    in_valid = 1'b0;
    if (timeout) begin
      for (int k = 1; k < TO; k++) begin
        @(negedge clk);
        check("no_early_timeout", W'(frame_valid), 0);
      end
      @(negedge clk);
      check("timeout_close", W'(frame_valid), 1);
    end else begin
      check("close_latency", W'(frame_valid), 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((frame_valid || sb.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", W'(sb.size()), 0);
  endtask

  // Monitor: compare each presented frame while it is held, then ack it.
  initial begin : monitor
    exp_t        cur;
    bit          have;
    int unsigned wait_cnt;
    have     = 1'b0;
    wait_cnt = 0;
    mon_ack  = 1'b0;
    forever begin
      @(negedge clk);
      mon_ack = 1'b0;
      if (frame_valid === 1'b1) begin
        if (!have) begin
          if (sb.size() == 0) begin
            check("unexpected_frame", W'(frame_len), 0);
          end else begin
            cur      = sb.pop_front();
            have     = 1'b1;
            wait_cnt = $urandom_range(0, 3);
          end
        end
        if (have) begin
          check("frame_data", frame_data, cur.data);
          check("frame_len", W'(frame_len), W'(cur.len));
          check("ready_low_in_done", W'(in_ready), 0);
`ifdef ASCII_CHECKSUM_EN
          check("frame_sum", W'(frame_sum), W'(cur.sum));
`endif
          if (!hold_ack) begin
            if (wait_cnt == 0) begin
              mon_ack = 1'b1;
              have    = 1'b0;
            end else begin
              wait_cnt--;
            end
          end
        end else if (!hold_ack) begin
          mon_ack = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    string      s;
    int         kind;
    int         n;
    logic [W-1:0] hi_exp;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    stim_ack = 1'b0;
    hold_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ready", W'(in_ready), 0);
    check("reset_valid", W'(frame_valid), 0);
    check("reset_len", W'(frame_len), 0);
    check("reset_data", frame_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", W'(in_ready), 1);

    // Full 24-byte frame ending in NUL, back-to-back bytes.
    s = "Hello CheckSum Project!";
    plan.delete();
    for (int i = 0; i < s.len(); i++) plan.push_back(s[i]);
    plan.push_back(8'h00);
    send_plan(0, 1'b0);
    check("t1_data", frame_data, 192'h48656C6C6F20436865636B53756D2050726F6A6563742100);
    check("t1_len", W'(frame_len), 24);
    drain();

    // Short NUL-terminated frame.
    plan = '{8'h48, 8'h69, 8'h00};
    send_plan(2, 1'b0);
    check("t2_top", W'(frame_data[W-1 -: 24]), 24'h486900);
    check("t2_rest", W'(frame_data[W-25:0]), 0);
    drain();

    // Partial frame closed by the idle timeout.
    plan = '{8'h41, 8'h42};
    send_plan(0, 1'b1);
    check("t3_top", W'(frame_data[W-1 -: 16]), 16'h4142);
    check("t3_len", W'(frame_len), 2);
    drain();

    // Held frame back-pressures the source until acked.
    hold_ack = 1'b1;
    plan = '{8'h48, 8'h69, 8'h00};
    send_plan(0, 1'b0);
    hi_exp = {24'h486900, {(W - 24){1'b0}}};
    in_data  = 8'h58;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_ready", W'(in_ready), 0);
      check("hold_valid", W'(frame_valid), 1);
      check("hold_data", frame_data, hi_exp);
    end
    hold_ack = 1'b0;
    plan = '{8'h58, 8'h00};
    send_plan(0, 1'b0);
    drain();

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    in_valid = 1'b0;
    check("partial_len", W'(frame_len), 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", W'(frame_valid), 0);
    check("midrst_len", W'(frame_len), 0);
    check("midrst_data", frame_data, 0);
    check("midrst_ready", W'(in_ready), 0);
`ifdef ASCII_CHECKSUM_EN
    check("midrst_sum", W'(frame_sum), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_up", W'(in_ready), 1);
    plan = '{8'h5A, 8'h00};
    send_plan(1, 1'b0);
    check("t5_top", W'(frame_data[W-1 -: 8]), 8'h5A);
    drain();

    // Ack while idle or filling is ignored.
    stim_ack = 1'b1;
    @(negedge clk);
    stim_ack = 1'b0;
    check("idle_ack_ready", W'(in_ready), 1);
    check("idle_ack_valid", W'(frame_valid), 0);
    plan = '{8'h51, 8'h52, 8'h53, 8'h00};
    push_plan();
    send_byte(8'h51);
    stim_ack = 1'b1;
    send_byte(8'h52);
    stim_ack = 1'b0;
    check("fill_ack_valid", W'(frame_valid), 0);
    send_byte(8'h53);
    send_byte(8'h00);
    in_valid = 1'b0;
    check("t6_close", W'(frame_valid), 1);
    drain();

    // Randomized frames: NUL-terminated, full-length, or timed out.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 2);
      plan.delete();
      if (kind == 0) begin
        n = $urandom_range(1, NB);
        for (int i = 0; i < n - 1; i++) plan.push_back(8'($urandom_range(1, 255)));
        plan.push_back(8'h00);
        send_plan(4, 1'b0);
      end else if (kind == 1) begin
        for (int i = 0; i < NB; i++) plan.push_back(8'($urandom_range(1, 255)));
        send_plan(4, 1'b0);
      end else begin
        n = $urandom_range(1, NB - 1);
        for (int i = 0; i < n; i++) plan.push_back(8'($urandom_range(1, 255)));
        send_plan(4, 1'b1);
      end
    end
    drain();
    repeat (5) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), 0);
    check("final_valid", W'(frame_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
